// File: rtl/bus_trans_if.sv
// Bus transaction interface: valid/ready request and response channels.
// The master side issues requests and accepts responses; the slave side does the opposite.
interface bus_trans_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  typedef struct packed {
    logic            cmd;     // 0 = read, 1 = write
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strobe;
  } req_pkt_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ok;
  } rsp_pkt_t;

  logic     req_vld;
  logic     req_rdy;
  req_pkt_t req_pkt;
  logic     rsp_vld;
  logic     rsp_rdy;
  rsp_pkt_t rsp_pkt;

  modport master (
    output req_vld, req_pkt, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_pkt
  );

  modport slave (
    input  req_vld, req_pkt, rsp_rdy,
    output req_rdy, rsp_vld, rsp_pkt
  );
endinterface

// File: rtl/bus_trans_arb.sv
// N-to-1 bus transaction arbiter with in-order response routing through an ID FIFO.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module bus_trans_arb #(
  parameter int NUM_MST   = 2,
  parameter int BTI_AW    = 32,
  parameter int BTI_DW    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  bus_trans_if.slave  s_bti [NUM_MST],
  bus_trans_if.master m_bti
);
  localparam int IDW   = $clog2(NUM_MST);
  localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW    = $clog2(MAX_OUTST + 1);
  localparam int REQ_W = 1 + BTI_AW + BTI_DW + BTI_DW / 8;

  logic [NUM_MST-1:0] req_vld;
  logic [NUM_MST-1:0] rsp_rdy;
  logic [REQ_W-1:0]   req_pkt [NUM_MST];

  logic [IDW-1:0] gnt;
  logic [IDW-1:0] gnt_q;
  logic [IDW-1:0] arb_gnt;
  logic [IDW-1:0] hid;
  logic           lock_q;
  logic           any_req;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  logic [IDW-1:0] id_mem [MAX_OUTST];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  for (genvar i = 0; i < NUM_MST; i++) begin : g_port
    assign req_vld[i]       = s_bti[i].req_vld;
    assign req_pkt[i]       = s_bti[i].req_pkt;
    assign rsp_rdy[i]       = s_bti[i].rsp_rdy;
    assign s_bti[i].req_rdy = (gnt == IDW'(i)) && m_bti.req_rdy && !full;
    assign s_bti[i].rsp_vld = (hid == IDW'(i)) && m_bti.rsp_vld && !empty;
    assign s_bti[i].rsp_pkt = m_bti.rsp_pkt;
  end

  assign any_req = |req_vld;
  assign full    = (count == CW'(MAX_OUTST));
  assign empty   = (count == '0);
  assign gnt     = lock_q ? gnt_q : arb_gnt;
  assign hid     = id_mem[rd_ptr];

  assign m_bti.req_vld = any_req && !full;
  assign m_bti.req_pkt = req_pkt[gnt];
  assign m_bti.rsp_rdy = rsp_rdy[hid] && !empty;

  assign push = m_bti.req_vld && m_bti.req_rdy;
  assign pop  = m_bti.rsp_vld && m_bti.rsp_rdy;

`ifdef BUS_ARB_RR_EN
  logic [IDW-1:0] rr;

  // Walk the search order backwards so the entry closest to rr is written last and wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    arb_gnt = rr;
    idx     = 0;
    cand    = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      cand = IDW'(idx);
      if (req_vld[cand]) arb_gnt = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (push) begin
      rr <= (gnt == IDW'(NUM_MST - 1)) ? '0 : gnt + IDW'(1);
    end
  end
`else
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    arb_gnt = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      if (req_vld[k]) arb_gnt = IDW'(k);
    end
  end
`endif

  // A stalled downstream request freezes the grant so req_pkt cannot change under the slave.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so update order never matters.
    if (rst) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (m_bti.req_vld && !m_bti.req_rdy) begin
        lock_q <= 1'b1;
        gnt_q  <= gnt;
      end else if (push) begin
        lock_q <= 1'b0;
      end

      if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the ID storage has no reset; count and pointers keep stale entries from being used.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt;
  end
endmodule

// File: tb/tb_bus_trans_arb.sv
// Directed self-checking bench for bus_trans_arb (NUM_MST=2, MAX_OUTST=4).
// Expected responses go into per-port scoreboard queues when requests are accepted.
module tb_bus_trans_arb;
  localparam int NM = 2;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_trans_if #(.AW(32), .DW(32)) s_bti [NM] ();
  bus_trans_if #(.AW(32), .DW(32)) m_bti ();

  bus_trans_arb #(
    .NUM_MST  (NM),
    .BTI_AW   (32),
    .BTI_DW   (32),
    .MAX_OUTST(MO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_bti(s_bti),
    .m_bti(m_bti)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] slv_q  [$];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  logic [NM-1:0] s_req_rdy;
  logic [NM-1:0] s_rsp_vld;
  logic [31:0]   s_rsp_data [NM];
  logic [NM-1:0] s_rsp_ok;

  for (genvar i = 0; i < NM; i++) begin : g_mon
    assign s_req_rdy[i]  = s_bti[i].req_rdy;
    assign s_rsp_vld[i]  = s_bti[i].rsp_vld;
    assign s_rsp_data[i] = s_bti[i].rsp_pkt.data;
    assign s_rsp_ok[i]   = s_bti[i].rsp_pkt.ok;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic vld, input logic cmd, input logic [31:0] addr);
    if (p == 0) begin
      s_bti[0].req_vld        = vld;
      s_bti[0].req_pkt.cmd    = cmd;
      s_bti[0].req_pkt.addr   = addr;
      s_bti[0].req_pkt.data   = addr ^ 32'hA5A5_A5A5;
      s_bti[0].req_pkt.strobe = 4'hF;
    end else begin
      s_bti[1].req_vld        = vld;
      s_bti[1].req_pkt.cmd    = cmd;
      s_bti[1].req_pkt.addr   = addr;
      s_bti[1].req_pkt.data   = addr ^ 32'hA5A5_A5A5;
      s_bti[1].req_pkt.strobe = 4'hF;
    end
  endtask

  task automatic sb_push(input int p, input logic [31:0] d);
    slv_q.push_back(d);
    if (p == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  task automatic sb_clear();
    slv_q.delete();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Slave presents the oldest pending response; the port given must be the one receiving it.
  task automatic rsp_present(input int p, input string tag);
    logic [31:0] d;
    logic [31:0] e;
    d = (slv_q.size() > 0) ? slv_q.pop_front() : 32'hBAD0_BAD0;
    m_bti.rsp_vld      = 1'b1;
    m_bti.rsp_pkt.data = d;
    m_bti.rsp_pkt.ok   = 1'b1;
    #1;
    check({tag, "_vld"},  s_rsp_vld, (p == 0) ? 2'b01 : 2'b10);
    check({tag, "_mrdy"}, m_bti.rsp_rdy, 1'b1);
    if (p == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hDEAD_0000;
    else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hDEAD_0001;
    check({tag, "_data"}, s_rsp_data[p], e);
    check({tag, "_ok"},   s_rsp_ok[p], 1'b1);
  endtask

  task automatic rsp_end();
    tick();
    m_bti.rsp_vld = 1'b0;
  endtask

  task automatic deliver(input int p, input string tag);
    rsp_present(p, tag);
    rsp_end();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req(0, 1'b0, 1'b0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0);
    s_bti[0].rsp_rdy   = 1'b1;
    s_bti[1].rsp_rdy   = 1'b1;
    m_bti.req_rdy      = 1'b0;
    m_bti.rsp_vld      = 1'b0;
    m_bti.rsp_pkt.data = '0;
    m_bti.rsp_pkt.ok   = 1'b0;
    tick();
    rst = 1'b0;
    sb_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;

    // Reset state, with a stray response and ready requesters to make the zeros meaningful
    do_reset();
    rst = 1'b1;
    m_bti.rsp_vld = 1'b1;
    tick();
    check("rst_mreqvld", m_bti.req_vld, 1'b0);
    check("rst_mrsprdy", m_bti.rsp_rdy, 1'b0);
    check("rst_sreqrdy", s_req_rdy, 2'b00);
    check("rst_srspvld", s_rsp_vld, 2'b00);
    m_bti.rsp_vld = 1'b0;
    rst = 1'b0;
    tick();

    // Single master read with a next-cycle response
    drive_req(0, 1'b1, 1'b0, 32'h0000_1000);
    m_bti.req_rdy = 1'b1;
    #1;
    check("t1_mvld", m_bti.req_vld, 1'b1);
    check("t1_addr", m_bti.req_pkt.addr, 32'h0000_1000);
    check("t1_cmd",  m_bti.req_pkt.cmd, 1'b0);
    check("t1_rdy",  s_req_rdy, 2'b01);
    sb_push(0, 32'hDEAD_BEEF);
    tick();
    drive_req(0, 1'b0, 1'b0, 32'h0);
    m_bti.req_rdy = 1'b0;
    deliver(0, "t1_rsp");
    m_bti.rsp_vld = 1'b1;
    #1;
    check("t1_stray_rdy", m_bti.rsp_rdy, 1'b0);
    check("t1_stray_vld", s_rsp_vld, 2'b00);
    m_bti.rsp_vld = 1'b0;

    // Contention until the FIFO fills, then the outstanding limit
    do_reset();
    drive_req(0, 1'b1, 1'b1, 32'h0000_2000);
    drive_req(1, 1'b1, 1'b1, 32'h0000_2100);
    m_bti.req_rdy = 1'b1;
    for (int k = 0; k < MO; k++) begin
`ifdef BUS_ARB_RR_EN
      g = k % 2;
`else
      g = 0;
`endif
      #1;
      check($sformatf("t2_gnt%0d", k),  s_req_rdy, (g == 0) ? 2'b01 : 2'b10);
      check($sformatf("t2_addr%0d", k), m_bti.req_pkt.addr, 32'h0000_2000 + 32'(g) * 32'h100);
      sb_push(g, 32'h5000_0000 + 32'(k));
      tick();
    end
    drive_req(1, 1'b0, 1'b1, 32'h0);
    #1;
    check("t2_full_mvld", m_bti.req_vld, 1'b0);
    check("t2_full_rdy",  s_req_rdy, 2'b00);
    rsp_present(0, "t2_pop");
    check("t2_pop_mvld", m_bti.req_vld, 1'b0);
    rsp_end();
    #1;
    check("t2_5th_mvld", m_bti.req_vld, 1'b1);
    check("t2_5th_rdy",  s_req_rdy, 2'b01);
    sb_push(0, 32'h5000_0004);
    tick();
    drive_req(0, 1'b0, 1'b1, 32'h0);
    m_bti.req_rdy = 1'b0;
    for (int k = 1; k < MO; k++) begin
`ifdef BUS_ARB_RR_EN
      g = k % 2;
`else
      g = 0;
`endif
      deliver(g, $sformatf("t2_drain%0d", k));
    end
    deliver(0, "t2_drain5");

    // Grant lock while the slave stalls
    do_reset();
    drive_req(1, 1'b1, 1'b1, 32'h0000_3100);
    #1;
    check("t3_c1_mvld", m_bti.req_vld, 1'b1);
    check("t3_c1_addr", m_bti.req_pkt.addr, 32'h0000_3100);
    check("t3_c1_rdy",  s_req_rdy, 2'b00);
    tick();
    drive_req(0, 1'b1, 1'b1, 32'h0000_3000);
    #1;
    check("t3_c2_addr", m_bti.req_pkt.addr, 32'h0000_3100);
    check("t3_c2_rdy",  s_req_rdy, 2'b00);
    tick();
    #1;
    check("t3_c3_addr", m_bti.req_pkt.addr, 32'h0000_3100);
    tick();
    m_bti.req_rdy = 1'b1;
    #1;
    check("t3_hs_rdy",  s_req_rdy, 2'b10);
    check("t3_hs_addr", m_bti.req_pkt.addr, 32'h0000_3100);
    sb_push(1, 32'h6000_0001);
    tick();
    drive_req(1, 1'b0, 1'b1, 32'h0);
    #1;
    check("t3_next_rdy",  s_req_rdy, 2'b01);
    check("t3_next_addr", m_bti.req_pkt.addr, 32'h0000_3000);
    sb_push(0, 32'h6000_0000);
    tick();
    drive_req(0, 1'b0, 1'b1, 32'h0);
    m_bti.req_rdy = 1'b0;
    deliver(1, "t3_rsp1");
    deliver(0, "t3_rsp0");

    // Interleaved routing 1,0,1 with a stalled requester
    do_reset();
    m_bti.req_rdy = 1'b1;
    drive_req(1, 1'b1, 1'b0, 32'h0000_4100);
    #1;
    check("t4_req_a", s_req_rdy, 2'b10);
    sb_push(1, 32'hAAAA_0001);
    tick();
    drive_req(1, 1'b0, 1'b0, 32'h0);
    drive_req(0, 1'b1, 1'b0, 32'h0000_4000);
    #1;
    check("t4_req_b", s_req_rdy, 2'b01);
    sb_push(0, 32'hBBBB_0002);
    tick();
    drive_req(0, 1'b0, 1'b0, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'h0000_4104);
    #1;
    check("t4_req_c", s_req_rdy, 2'b10);
    sb_push(1, 32'hCCCC_0003);
    tick();
    drive_req(1, 1'b0, 1'b0, 32'h0);
    m_bti.req_rdy = 1'b0;
    deliver(1, "t4_a");
    s_bti[0].rsp_rdy   = 1'b0;
    m_bti.rsp_vld      = 1'b1;
    m_bti.rsp_pkt.data = 32'hBBBB_0002;
    #1;
    check("t4_stall_vld",  s_rsp_vld, 2'b01);
    check("t4_stall_mrdy", m_bti.rsp_rdy, 1'b0);
    tick();
    #1;
    check("t4_stall2_mrdy", m_bti.rsp_rdy, 1'b0);
    s_bti[0].rsp_rdy = 1'b1;
    deliver(0, "t4_b");
    deliver(1, "t4_c");

    // Reset with three outstanding transactions
    do_reset();
    m_bti.req_rdy = 1'b1;
    drive_req(0, 1'b1, 1'b1, 32'h0000_7000);
    repeat (3) tick();
    drive_req(0, 1'b0, 1'b1, 32'h0);
    m_bti.req_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_clear();
    m_bti.rsp_vld = 1'b1;
    #1;
    check("t5_mreqvld", m_bti.req_vld, 1'b0);
    check("t5_mrsprdy", m_bti.rsp_rdy, 1'b0);
    check("t5_sreqrdy", s_req_rdy, 2'b00);
    check("t5_srspvld", s_rsp_vld, 2'b00);
    m_bti.rsp_vld = 1'b0;
    tick();
    drive_req(1, 1'b1, 1'b0, 32'h0000_7100);
    m_bti.req_rdy = 1'b1;
    #1;
    check("t5_new_rdy", s_req_rdy, 2'b10);
    sb_push(1, 32'h7777_0001);
    tick();
    drive_req(1, 1'b0, 1'b0, 32'h0);
    m_bti.req_rdy = 1'b0;
    deliver(1, "t5_rsp");
    m_bti.rsp_vld = 1'b1;
    #1;
    check("t5_empty_mrdy", m_bti.rsp_rdy, 1'b0);
    m_bti.rsp_vld = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_trans_arb.md
# bus_trans_arb

N-to-1 arbiter for the bus transaction interface: merges `NUM_MST` upstream requesters (core fetch, core load/store, debug, DMA) onto one downstream slave port. It tracks outstanding transactions so that every in-order response returns to the requester that issued it. It sits between the initiators and the memory/peripheral interconnect and uses the same valid/ready req/rsp protocol on every port.

## Interface
- `NUM_MST`, 2: number of upstream requesters; ≥2. `IDW = $clog2(NUM_MST)`.
- `BTI_AW`, 32: address width, all ports.
- `BTI_DW`, 32: data width, all ports; strobe is `BTI_DW/8`.
- `MAX_OUTST`, 4: maximum accepted-but-unanswered transactions; ≥1.
- `clk`  input  1  clock, all logic on rising edge.
- `rst`  input  1  synchronous active-high reset.
- `s_bti[NUM_MST]`  bus_trans_if.slave  array  upstream ports; requesters drive these.
- `m_bti`  bus_trans_if.master  1  downstream port to the slave.

## Operation
- Requester `i` is requesting when `s_bti[i].req_vld` is high.
- Request path is combinational:
  - `m_bti.req_vld = (any request) && !full`.
  - `m_bti.req_pkt = s_bti[gnt].req_pkt`.
  - `s_bti[gnt].req_rdy = m_bti.req_rdy && !full`. All other `req_rdy` are 0.
- Grant selection:
  - Grant lock: if `m_bti.req_vld && !m_bti.req_rdy`, register `gnt` and set `lock`. While `lock` is set, `gnt` is held, so `req_pkt` stays stable to the slave.
  - `lock` clears on the downstream request handshake.
  - When unlocked, `gnt` comes from the arbitration policy (see Configuration).
- Accept: a request is accepted when `m_bti.req_vld && m_bti.req_rdy`. On accept, `gnt` is pushed into the ID FIFO (depth `MAX_OUTST`, width `IDW`).
- `full`: `count == MAX_OUTST`. While full, `m_bti.req_vld = 0` even if the same cycle pops a response. There is no combinational path from rsp to req.
- Response path is combinational, routed by FIFO head `hid`:
  - `s_bti[hid].rsp_vld = m_bti.rsp_vld && !empty`.
  - `s_bti[hid].rsp_pkt = m_bti.rsp_pkt`.
  - `m_bti.rsp_rdy = s_bti[hid].rsp_rdy && !empty`.
  - Other ports get `rsp_vld = 0`. `rsp_pkt` is broadcast to all ports.
- Pop: the FIFO pops on the downstream response handshake.
- Empty FIFO: `m_bti.rsp_rdy = 0`. A stray response stalls and is never delivered.
- Push and pop in the same cycle (not full): `count` is unchanged and both pointers advance.
- Pointers wrap modulo `MAX_OUTST`; non-power-of-2 depths are supported by an explicit compare-and-reset.
- Ordering: the slave returns responses in request order. The block does not reorder.
- `cmd`, `addr`, `data`, `strobe`, `ok` pass through unmodified.

## Timing
- Request and response paths: zero-cycle latency, purely combinational through the mux. All state is registered.
- Reset (`rst`=1 at a clock edge):
  - `count`=0, pointers=0, `lock`=0, `gnt`=0, round-robin pointer=0.
  - Consequently `m_bti.req_vld`=0, `m_bti.rsp_rdy`=0, all `s_bti[i].req_rdy`=0, all `s_bti[i].rsp_vld`=0.
- Reset mid-operation discards outstanding IDs. The system resets the slave in the same cycle.
- Throughput: one request accept and one response delivery per cycle, sustained while `0 < count < MAX_OUTST`.
- Outstanding limit: with `MAX_OUTST` outstanding and the slave responding in 1 cycle, the next request accept happens one cycle after the pop.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin arbitration.
  - A pointer `rr` holds the highest-priority index. Search order is `rr, rr+1, …` modulo `NUM_MST`.
  - On each accept, `rr <= gnt+1` (wrapping).
- `BUS_ARB_RR_EN` undefined: fixed priority, lowest index wins.
  - No `rr` register exists; lock behaviour is identical.

## Test plan
- Single master, `NUM_MST`=2: port 0 issues read at `addr`=0x1000, slave ready, rsp `data`=0xDEADBEEF `ok`=1 next cycle → `m_bti.req_pkt.addr`=0x1000 the same cycle; port 0 gets rsp 0xDEADBEEF; port 1 `rsp_vld` stays 0.
- Contention, RR: ports 0 and 1 request continuously, slave always ready → grants alternate 0,1,0,1. Without `BUS_ARB_RR_EN` → port 0 granted every cycle.
- Lock: port 1 requests with slave `req_rdy`=0 for 3 cycles, port 0 raises `req_vld` in cycle 2 → `gnt` stays 1 and `req_pkt` is unchanged until the handshake; port 0 granted the following cycle.
- Full, `MAX_OUTST`=4: issue 4 writes, responses withheld → `m_bti.req_vld`=0 with a 5th request pending. Release one rsp → the 5th is accepted one cycle after the pop.
- Routing: interleaved requests from ports 1,0,1 with slave responses A,B,C → port 1 receives A then C, port 0 receives B. Stalling port 0 `rsp_rdy` holds `m_bti.rsp_rdy`=0.
- Reset with 3 outstanding → all outputs 0 the next cycle; a new request is accepted with `count` restarting at 1.
